// File: rtl/req_pkg.sv
// Shared definitions for the request arbiter and the request bridge it fronts.
package req_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int REQ_LEN_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // A length field of zero stands for a full 8-beat burst.
  function automatic logic [3:0] len_to_beats(input logic [REQ_LEN_W-1:0] len);
    return (len == '0) ? 4'd8 : {1'b0, len};
  endfunction

endpackage

// File: rtl/req_arbiter.sv
// Two-master arbiter for the bridge request channel; the grant is held for a whole burst.
// Handshake: a transfer happens on a clock edge where valid and ready are both high; valid never waits on ready.
module req_arbiter
  import req_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 m0_req_valid,
  output logic                 m0_req_ready,
  input  logic [DATA_W/8-1:0]  m0_req_mask,
  input  logic [ADDR_W-1:0]    m0_req_addr,
  input  logic [2:0]           m0_req_len,
  input  logic                 m0_req_we,
  input  logic                 m0_write_valid,
  input  logic [DATA_W-1:0]    m0_write_data,
  output logic                 m0_read_valid,
  output logic [DATA_W-1:0]    m0_read_data,
  input  logic                 m0_read_ack,
  input  logic                 m1_req_valid,
  output logic                 m1_req_ready,
  input  logic [DATA_W/8-1:0]  m1_req_mask,
  input  logic [ADDR_W-1:0]    m1_req_addr,
  input  logic [2:0]           m1_req_len,
  input  logic                 m1_req_we,
  input  logic                 m1_write_valid,
  input  logic [DATA_W-1:0]    m1_write_data,
  output logic                 m1_read_valid,
  output logic [DATA_W-1:0]    m1_read_data,
  input  logic                 m1_read_ack,
  output logic                 s_req_valid,
  input  logic                 s_req_ready,
  output logic [DATA_W/8-1:0]  s_req_mask,
  output logic [ADDR_W-1:0]    s_req_addr,
  output logic [2:0]           s_req_len,
  output logic                 s_req_we,
  output logic                 s_write_valid,
  output logic [DATA_W-1:0]    s_write_data,
  input  logic                 s_read_valid,
  input  logic [DATA_W-1:0]    s_read_data,
  output logic                 s_read_ack,
  output logic [1:0]           gnt_o,
  output logic [1:0]           dbg_state_o
);

  // On a tie the master that did not win last time is chosen.
  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return ~last;
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_owner, r_last, r_we_q;
  logic [3:0]  r_rem;

  logic                w_active, w_winner, w_beat, w_hs;
  logic [3:0]          w_rem_nxt;
  logic                w_req_valid, w_req_we, w_write_valid, w_read_ack;
  logic [DATA_W/8-1:0] w_req_mask;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [2:0]          w_req_len;
  logic [DATA_W-1:0]   w_write_data;

  assign w_active      = (r_state != ST_IDLE);
  assign w_winner      = pick(m0_req_valid, m1_req_valid, r_last);
  assign w_req_valid   = r_owner ? m1_req_valid   : m0_req_valid;
  assign w_req_mask    = r_owner ? m1_req_mask    : m0_req_mask;
  assign w_req_addr    = r_owner ? m1_req_addr    : m0_req_addr;
  assign w_req_len     = r_owner ? m1_req_len     : m0_req_len;
  assign w_req_we      = r_owner ? m1_req_we      : m0_req_we;
  assign w_write_valid = r_owner ? m1_write_valid : m0_write_valid;
  assign w_write_data  = r_owner ? m1_write_data  : m0_write_data;
  assign w_read_ack    = r_owner ? m1_read_ack    : m0_read_ack;

  assign w_hs = (r_state == ST_REQ) && w_req_valid && s_req_ready;

  // Write pushes may arrive before the request handshake; read beats only after it.
  assign w_beat = w_active && (r_rem != 4'd0) &&
                  (r_we_q ? w_write_valid
                          : ((r_state == ST_DATA) && s_read_valid && w_read_ack));
  assign w_rem_nxt = r_rem - {3'b000, w_beat};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (m0_req_valid || m1_req_valid) w_state_nxt = ST_REQ;
      ST_REQ:  if (w_hs) w_state_nxt = (w_rem_nxt == 4'd0) ? ST_IDLE : ST_DATA;
      ST_DATA: if (w_rem_nxt == 4'd0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_rem   <= 4'd0;
      r_we_q  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (m0_req_valid || m1_req_valid) begin
        r_owner <= w_winner;
        r_last  <= w_winner;
        r_rem   <= len_to_beats(w_winner ? m1_req_len : m0_req_len);
        r_we_q  <= w_winner ? m1_req_we : m0_req_we;
      end
    end else begin
      r_rem <= w_rem_nxt;
    end
  end

  // Everything is forced to zero in IDLE so an async reset clears outputs without a clock.
  always_comb begin
    gnt_o         = 2'b00;
    dbg_state_o   = r_state;
    s_req_valid   = 1'b0;
    s_req_mask    = '0;
    s_req_addr    = '0;
    s_req_len     = '0;
    s_req_we      = 1'b0;
    s_write_valid = 1'b0;
    s_write_data  = '0;
    s_read_ack    = 1'b0;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    m0_read_valid = 1'b0;
    m1_read_valid = 1'b0;
    m0_read_data  = '0;
    m1_read_data  = '0;
    if (w_active) begin
      gnt_o       = r_owner ? 2'b10 : 2'b01;
      s_req_valid = (r_state == ST_REQ) && w_req_valid;
      s_req_mask  = w_req_mask;
      s_req_addr  = w_req_addr;
      s_req_len   = w_req_len;
      s_req_we    = w_req_we;
      s_read_ack  = w_read_ack;
      if (r_we_q) begin
        s_write_valid = w_write_valid && (r_rem != 4'd0);
        s_write_data  = w_write_data;
      end
      if (r_owner) begin
        m1_req_ready  = (r_state == ST_REQ) && s_req_ready;
        m1_read_valid = s_read_valid;
        m1_read_data  = s_read_data;
      end else begin
        m0_req_ready  = (r_state == ST_REQ) && s_req_ready;
        m0_read_valid = s_read_valid;
        m0_read_data  = s_read_data;
      end
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter: a stimulus thread queues expected transfers, a monitor pops and compares them.
module tb_req_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_write_valid, m0_read_valid, m0_read_ack;
  logic [3:0]  m0_req_mask;
  logic [31:0] m0_req_addr, m0_write_data, m0_read_data;
  logic [2:0]  m0_req_len;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_write_valid, m1_read_valid, m1_read_ack;
  logic [3:0]  m1_req_mask;
  logic [31:0] m1_req_addr, m1_write_data, m1_read_data;
  logic [2:0]  m1_req_len;
  logic        s_req_valid, s_req_ready, s_req_we, s_write_valid, s_read_valid, s_read_ack;
  logic [3:0]  s_req_mask;
  logic [31:0] s_req_addr, s_write_data, s_read_data;
  logic [2:0]  s_req_len;
  logic [1:0]  gnt_o, dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [37:0] exp_req_q[$];
  logic [31:0] exp_wr_q[$];
  logic [32:0] exp_rd_q[$];

  req_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_mask(m0_req_mask),
    .m0_req_addr(m0_req_addr), .m0_req_len(m0_req_len), .m0_req_we(m0_req_we),
    .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
    .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data), .m0_read_ack(m0_read_ack),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_mask(m1_req_mask),
    .m1_req_addr(m1_req_addr), .m1_req_len(m1_req_len), .m1_req_we(m1_req_we),
    .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
    .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data), .m1_read_ack(m1_read_ack),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_mask(s_req_mask),
    .s_req_addr(s_req_addr), .s_req_len(s_req_len), .s_req_we(s_req_we),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data),
    .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(s_read_ack),
    .gnt_o(gnt_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] status();
    return {gnt_o, s_req_valid, s_write_valid, s_read_ack,
            m0_req_ready, m1_req_ready, m0_read_valid, m1_read_valid};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int m, input logic [31:0] addr, input logic [2:0] len, input logic we);
    if (m == 0) begin
      m0_req_addr = addr; m0_req_len = len; m0_req_we = we; m0_req_mask = 4'hF; m0_req_valid = 1'b1;
    end else begin
      m1_req_addr = addr; m1_req_len = len; m1_req_we = we; m1_req_mask = 4'hF; m1_req_valid = 1'b1;
    end
    exp_req_q.push_back({(m == 0) ? 2'b01 : 2'b10, we, len, addr});
  endtask

  task automatic wait_hs(output int who);
    logic h0, h1;
    who = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      h0 = m0_req_ready;
      h1 = m1_req_ready;
      @(posedge clk_i);
      #1;
      if (h0) begin m0_req_valid = 1'b0; who = 0; break; end
      if (h1) begin m1_req_valid = 1'b0; who = 1; break; end
    end
    if (who < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL hs_timeout: got no req_ready expected handshake within 40 cycles");
    end
  endtask

  task automatic push_write(input int m, input logic [31:0] data, input logic [1:0] exp_gnt);
    if (m == 0) begin m0_write_valid = 1'b1; m0_write_data = data; end
    else        begin m1_write_valid = 1'b1; m1_write_data = data; end
    exp_wr_q.push_back(data);
    @(negedge clk_i);
    check("gnt_during_push", gnt_o, exp_gnt);
    @(posedge clk_i);
    #1;
    m0_write_valid = 1'b0;
    m1_write_valid = 1'b0;
  endtask

  task automatic ack_read(input int m, input logic [31:0] data);
    s_read_valid = 1'b1;
    s_read_data  = data;
    if (m == 0) m0_read_ack = 1'b1;
    else        m1_read_ack = 1'b1;
    exp_rd_q.push_back({m[0], data});
    @(posedge clk_i);
    #1;
    s_read_valid = 1'b0;
    m0_read_ack  = 1'b0;
    m1_read_ack  = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (s_req_valid && s_req_ready) begin
        if (exp_req_q.size() == 0) check("req_unexpected", {gnt_o, s_req_addr}, 0);
        else check("req_fields", {gnt_o, s_req_we, s_req_len, s_req_addr}, exp_req_q.pop_front());
      end
      if (s_write_valid) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", s_write_data, 64'hDEAD);
        else check("wr_data", s_write_data, exp_wr_q.pop_front());
      end
      if (m0_read_valid && m0_read_ack) begin
        if (exp_rd_q.size() == 0) check("rd0_unexpected", m0_read_data, 64'hDEAD);
        else check("rd0_data", {1'b0, m0_read_data}, exp_rd_q.pop_front());
      end
      if (m1_read_valid && m1_read_ack) begin
        if (exp_rd_q.size() == 0) check("rd1_unexpected", m1_read_data, 64'hDEAD);
        else check("rd1_data", {1'b1, m1_read_data}, exp_rd_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int who;
    int rr_exp[3];
    rr_exp = '{0, 1, 0};
    rst_ni = 1'b0;
    {m0_req_valid, m0_req_we, m0_write_valid, m0_read_ack} = '0;
    {m1_req_valid, m1_req_we, m1_write_valid, m1_read_ack} = '0;
    m0_req_mask = '0; m0_req_addr = '0; m0_req_len = '0; m0_write_data = '0;
    m1_req_mask = '0; m1_req_addr = '0; m1_req_len = '0; m1_write_data = '0;
    s_req_ready = 1'b1; s_read_valid = 1'b0; s_read_data = '0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", status(), 9'd0);
    check("reset_state", dbg_state_o, 2'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // single m0 write, len 2
    @(posedge clk_i);
    #1 set_req(0, 32'h100, 3'd2, 1'b1);
    @(negedge clk_i);
    check("lat_idle_no_req", s_req_valid, 1'b0);
    @(negedge clk_i);
    check("lat_req_valid", s_req_valid, 1'b1);
    check("t1_gnt", gnt_o, 2'b01);
    @(posedge clk_i);
    #1 m0_req_valid = 1'b0;
    push_write(0, 32'hA, 2'b01);
    push_write(0, 32'hB, 2'b01);
    @(negedge clk_i);
    check("t1_gnt_clear", gnt_o, 2'b00);

    // tie after reset: m0 first, then m1
    do_reset();
    set_req(0, 32'h200, 3'd4, 1'b0);
    set_req(1, 32'h300, 3'd1, 1'b0);
    wait_hs(who);
    check("tie_first_m0", who, 0);
    for (int i = 0; i < 4; i++) ack_read(0, 32'h11 * (i + 1));
    wait_hs(who);
    check("tie_then_m1", who, 1);
    ack_read(1, 32'hC0DE);

    // round robin on repeated ties (last winner is m1 here)
    set_req(0, 32'h400, 3'd1, 1'b0);
    set_req(1, 32'h500, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_hs(who);
      check("rr_order", who, rr_exp[k]);
      ack_read(who, 32'h1000 + k);
      if (k < 2) set_req(who, (who == 0) ? 32'h400 : 32'h500, 3'd1, 1'b0);
    end
    wait_hs(who);
    check("rr_tail_m1", who, 1);
    ack_read(1, 32'h2000);

    // m1 write len 0 = 8 beats; m0 waits for the whole burst
    set_req(1, 32'h600, 3'd0, 1'b1);
    wait_hs(who);
    check("len8_grant_m1", who, 1);
    set_req(0, 32'h700, 3'd1, 1'b0);
    for (int i = 0; i < 8; i++) push_write(1, 32'h3000 + i, 2'b10);
    @(negedge clk_i);
    check("len8_gnt_clear", gnt_o, 2'b00);
    wait_hs(who);
    check("len8_m0_after", who, 0);
    ack_read(0, 32'h4444);

    // non-owner pushes and acks are dropped
    set_req(0, 32'h800, 3'd2, 1'b0);
    wait_hs(who);
    m1_write_valid = 1'b1; m1_write_data = 32'hBAD; m1_read_ack = 1'b1;
    s_read_valid = 1'b1; s_read_data = 32'h55;
    @(negedge clk_i);
    check("viol_s_write_valid", s_write_valid, 1'b0);
    check("viol_s_read_ack", s_read_ack, 1'b0);
    check("viol_m1_read_valid", m1_read_valid, 1'b0);
    check("viol_m0_read_valid", m0_read_valid, 1'b1);
    @(posedge clk_i);
    #1 m1_write_valid = 1'b0; m1_read_ack = 1'b0; s_read_valid = 1'b0;
    ack_read(0, 32'h5501);
    ack_read(0, 32'h5502);

    // async reset mid-burst clears outputs without a clock edge
    set_req(0, 32'h900, 3'd3, 1'b0);
    wait_hs(who);
    s_read_valid = 1'b1; s_read_data = 32'h77; m0_read_ack = 1'b1;
    #1;
    check("prereset_status", status(), 9'b01_0_0_1_0_0_1_0);
    check("prereset_rdata", m0_read_data, 32'h77);
    rst_ni = 1'b0;
    #1;
    check("async_reset_status", status(), 9'd0);
    check("async_reset_rdata", m0_read_data, 32'h0);
    s_read_valid = 1'b0; m0_read_ack = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    set_req(0, 32'hA00, 3'd1, 1'b0);
    set_req(1, 32'hB00, 3'd1, 1'b0);
    wait_hs(who);
    check("post_reset_tie_m0", who, 0);
    ack_read(0, 32'hA0A0);
    wait_hs(who);
    check("post_reset_then_m1", who, 1);
    ack_read(1, 32'hB0B0);

    repeat (3) @(posedge clk_i);
    check("req_q_drained", exp_req_q.size(), 0);
    check("wr_q_drained", exp_wr_q.size(), 0);
    check("rd_q_drained", exp_rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
